cpu_controller: RTL and testbench

// Multi-cycle control FSM for the 16-bit CPU. Owns PC and instruction register, fetches

---
 rtl/cpu_pkg.sv | 79 +++++++
 rtl/cond_eval.sv | 36 +++
 rtl/cpu_controller.sv | 144 ++++++++++++++
 tb/tb_cpu_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, condition codes and FSM states shared by
// the controller and decoder of the 16-bit CPU.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3
  } state_e;

  // IR[15:12] major opcodes
  localparam logic [3:0] OP_RR    = 4'h0;
  localparam logic [3:0] OP_LDST  = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_BCOND = 4'hC;

  // RR extension IR[7:4]; the immediate
  // form reuses the same value in IR[15:12]
  localparam logic [3:0] EX_AND = 4'h1;
  localparam logic [3:0] EX_OR  = 4'h2;
  localparam logic [3:0] EX_XOR = 4'h3;
  localparam logic [3:0] EX_ADD = 4'h5;
  localparam logic [3:0] EX_SUB = 4'h9;
  localparam logic [3:0] EX_CMP = 4'hB;
  localparam logic [3:0] EX_MOV = 4'hD;
  localparam logic [3:0] EX_MUL = 4'hE;

  // shift group extensions (LSHI/ASHUI carry a sign bit)
  localparam logic [3:0] EX_LSHI_L = 4'h0;
  localparam logic [3:0] EX_LSHI_R = 4'h1;
  localparam logic [3:0] EX_ASHI_L = 4'h2;
  localparam logic [3:0] EX_ASHI_R = 4'h3;
  localparam logic [3:0] EX_LSH    = 4'h4;
  localparam logic [3:0] EX_ASHU   = 4'h6;

  // load/store/jump group extensions
  localparam logic [3:0] EX_LOAD  = 4'h0;
  localparam logic [3:0] EX_STOR  = 4'h4;
  localparam logic [3:0] EX_JCOND = 4'hC;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  function automatic logic is_alu_ext(
    input logic [3:0] e
  );
    return e inside {EX_AND, EX_OR, EX_XOR,
      EX_ADD, EX_SUB, EX_MOV, EX_MUL};
  endfunction

  function automatic logic is_flag_ext(
    input logic [3:0] e
  );
    return e inside {EX_ADD, EX_SUB, EX_CMP};
  endfunction

  function automatic logic is_shift_ext(
    input logic [3:0] e
  );
    return e inside {EX_LSHI_L, EX_LSHI_R,
      EX_ASHI_L, EX_ASHI_R, EX_LSH, EX_ASHU};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: branch/jump condition check.
// cond_i[3:0], flags_i {C,L,F,Z,N} -> taken_o.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic c, l, f, z, n;
  assign {c, l, f, z, n} = flags_i;

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      CC_EQ: taken_o = z;
      CC_NE: taken_o = !z;
      CC_CS: taken_o = c;
      CC_CC: taken_o = !c;
      CC_HI: taken_o = l;
      CC_LS: taken_o = !l;
      CC_GT: taken_o = n;
      CC_LE: taken_o = !n;
      CC_FS: taken_o = f;
      CC_FC: taken_o = !f;
      CC_LO: taken_o = !z && !l;
      CC_HS: taken_o = z || l;
      CC_LT: taken_o = !z && !n;
      CC_GE: taken_o = z || n;
      CC_UC: taken_o = 1'b1;
      CC_NV: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH/DECODE/EXEC/MEM control FSM.
// Owns pc/ir; drives mem_req/mem_we/mem_addr_sel, rf_we, wb_sel, flags_we.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [4:0]  flags,
  input  logic [15:0] rsrc_data,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        flags_we,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] iaddr_q, iaddr_d;

  logic [3:0] op_hi, op_lo;
  logic       is_alu, is_flg;
  logic       is_ld, is_st;
  logic       is_jc, is_bc;
  logic       taken;

  assign op_hi = ir_q[15:12];
  assign op_lo = ir_q[7:4];

  cond_eval u_cond (
    .cond_i  (ir_q[11:8]),
    .flags_i (flags),
    .taken_o (taken)
  );

  always_comb begin
    is_alu = 1'b0;
    is_flg = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_jc  = 1'b0;
    is_bc  = 1'b0;
    unique case (op_hi)
      OP_RR: begin
        is_alu = is_alu_ext(op_lo);
        is_flg = is_flag_ext(op_lo);
      end
      OP_SHIFT: is_alu = is_shift_ext(op_lo);
      OP_LDST: begin
        is_ld = (op_lo == EX_LOAD);
        is_st = (op_lo == EX_STOR);
        is_jc = (op_lo == EX_JCOND);
      end
      OP_BCOND: is_bc = 1'b1;
      default: begin
        is_alu = is_alu_ext(op_hi);
        is_flg = is_flag_ext(op_hi);
      end
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    flags_we     = 1'b0;
    unique case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        rf_we    = is_alu;
        flags_we = is_flg;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        rf_we        = is_ld && mem_ready;
        wb_sel       = is_ld && mem_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    iaddr_d = iaddr_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          iaddr_d = pc_q;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = (is_ld || is_st) ? S_MEM : S_FETCH;
        // branch displacement is relative to the
        // branch's own address, not pc+1
        if (is_bc && taken)
          pc_d = iaddr_q + {{8{ir_q[7]}}, ir_q[7:0]};
        if (is_jc && taken)
          pc_d = rsrc_data;
      end
      S_MEM: begin
        if (mem_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 16'h0000;
      iaddr_q <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      iaddr_q <= iaddr_d;
    end
  end

  assign ir    = ir_q;
  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed vector table, reset corner
// sequences and random instructions against a reference model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [15:0] rsrc_data;
  logic [15:0] ir, pc;
  logic        mem_req, mem_we, mem_addr_sel;
  logic        rf_we, wb_sel, flags_we;
  logic [2:0]  state;

  cpu_controller #(.PC_RESET(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .flags        (flags),
    .rsrc_data    (rsrc_data),
    .ir           (ir),
    .pc           (pc),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .flags_we     (flags_we),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rf;
    bit          fl;
    bit          ld;
    bit          st;
    logic [15:0] npc;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic [4:0]  f;
    logic [15:0] rs;
    int          fw;
    int          mw;
    bit          rf;
    bit          fl;
    bit          ld;
    bit          st;
    logic [15:0] npc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_ir;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Instruction-level reference: what one instruction should do overall.
  function automatic exp_t model(input logic [15:0] ins,
                                 input logic [4:0]  f,
                                 input logic [15:0] rs,
                                 input logic [15:0] ia);
    exp_t e;
    logic [3:0]  hi, lo;
    logic [15:0] take, alu_m, flg_m, sh_m;
    logic c, l, g, z, n;
    hi = ins[15:12];
    lo = ins[7:4];
    {c, l, g, z, n} = f;
    take  = {1'b0, 1'b1, z | n, ~z & ~n, z | l, ~z & ~l,
             ~g, g, ~n, n, ~l, l, ~c, c, ~z, z};
    alu_m = 16'h622E;
    flg_m = 16'h0A20;
    sh_m  = 16'h005F;
    e.rf = 0; e.fl = 0; e.ld = 0; e.st = 0;
    e.npc = ia + 16'd1;
    if (hi == 4'h0) begin
      e.rf = alu_m[lo];
      e.fl = flg_m[lo];
    end else if (hi == 4'h8) begin
      e.rf = sh_m[lo];
    end else if (hi == 4'h4) begin
      e.ld = (lo == 4'h0);
      e.rf = (lo == 4'h0);
      e.st = (lo == 4'h4);
      if (lo == 4'hC && take[ins[11:8]]) e.npc = rs;
    end else if (hi == 4'hC) begin
      if (take[ins[11:8]])
        e.npc = ia + 16'($signed(ins[7:0]));
    end else begin
      e.rf = alu_m[hi];
      e.fl = flg_m[hi];
    end
    return e;
  endfunction

  // Run one instruction from a FETCH-state negedge to the next FETCH.
  task automatic run(input logic [15:0] ins,
                     input logic [4:0]  f,
                     input logic [15:0] rs,
                     input int fw, input int mw,
                     input exp_t e, input string tag);
    int cyc = 0, w;
    int nrf = 0, nld = 0, nfl = 0, nwe = 0, ndm = 0;
    bit fetched = 0, hold_ok = 1, done = 0, tmo = 0;
    bit mem_op;
    logic [15:0] ia;
    ia = exp_pc;
    mem_op = e.ld || e.st;
    flags = f;
    rsrc_data = rs;
    w = fw;
    while (!done) begin
      if (fetched && state == 3'd0) begin
        done = 1;
      end else if (cyc >= 64) begin
        tmo = 1;
        done = 1;
      end else begin
        mem_rdata = fetched ? ~ins : ins;
        mem_ready = 1'b0;
        if (mem_req) begin
          if (w > 0) w--;
          else mem_ready = 1'b1;
        end
        #1;
        if (!fetched && (pc !== ia || ir !== exp_ir))
          hold_ok = 0;
        if (rf_we) nrf++;
        if (rf_we && wb_sel) nld++;
        if (flags_we) nfl++;
        if (mem_we) nwe++;
        if (mem_req && mem_addr_sel) ndm++;
        if (mem_ready && !fetched) begin
          fetched = 1;
          w = mw;
        end
        cyc++;
        @(negedge clk);
      end
    end
    chk({tag, ".timeout"}, 32'(tmo), 0);
    chk({tag, ".cycles"}, cyc, mem_op ? 4 + fw + mw : 3 + fw);
    chk({tag, ".pc"}, pc, e.npc);
    chk({tag, ".ir"}, ir, ins);
    chk({tag, ".hold"}, 32'(hold_ok), 1);
    chk({tag, ".rf_we"}, nrf, 32'(e.rf));
    chk({tag, ".load_wb"}, nld, 32'(e.ld));
    chk({tag, ".flags_we"}, nfl, 32'(e.fl));
    chk({tag, ".mem_we"}, nwe, e.st ? 1 + mw : 0);
    chk({tag, ".data_req"}, ndm, mem_op ? 1 + mw : 0);
    exp_pc = e.npc;
    exp_ir = ins;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 16'h0000;
    exp_ir = 16'h0000;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".pc"}, pc, 16'h0000);
    chk({tag, ".ir"}, ir, 16'h0000);
    chk({tag, ".mem_req"}, mem_req, 1);
    chk({tag, ".strobes"},
        {mem_we, mem_addr_sel, rf_we, wb_sel, flags_we}, 0);
  endtask

  function automatic logic [15:0] rnd_ins();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: r[15:12] = 4'h0;
      1: begin
        r[15:12] = 4'h4;
        case ($urandom_range(0, 2))
          0: r[7:4] = 4'h0;
          1: r[7:4] = 4'h4;
          default: r[7:4] = 4'hC;
        endcase
      end
      2: r[15:12] = 4'hC;
      3: r[15:12] = 4'h8;
      default: ;
    endcase
    return r;
  endfunction

  vec_t vt[18];
  exp_t ev;

  initial begin
    vt[0]  = '{16'h5105, 5'h00, 16'h0000, 0, 0, 1, 1, 0, 0, 16'h0001};
    vt[1]  = '{16'h0152, 5'h00, 16'h0000, 3, 0, 1, 1, 0, 0, 16'h0002};
    vt[2]  = '{16'h01B2, 5'h00, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0003};
    vt[3]  = '{16'h02D3, 5'h00, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h0004};
    vt[4]  = '{16'h4203, 5'h00, 16'h0000, 0, 2, 1, 0, 1, 0, 16'h0005};
    vt[5]  = '{16'h4243, 5'h00, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0006};
    vt[6]  = '{16'h4EC5, 5'h00, 16'h0010, 0, 0, 0, 0, 0, 0, 16'h0010};
    vt[7]  = '{16'hC0FE, 5'h02, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h000E};
    vt[8]  = '{16'hC0FE, 5'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h000F};
    vt[9]  = '{16'hCFFE, 5'h1F, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0010};
    vt[10] = '{16'h4EC1, 5'h00, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'hFFFF};
    vt[11] = '{16'h0000, 5'h00, 16'h0000, 2, 0, 0, 0, 0, 0, 16'h0000};
    vt[12] = '{16'h4EC2, 5'h00, 16'h1234, 0, 0, 0, 0, 0, 0, 16'h1234};
    vt[13] = '{16'h4FC0, 5'h1F, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1235};
    vt[14] = '{16'h8101, 5'h00, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h1236};
    vt[15] = '{16'hC1FE, 5'h02, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1237};
    vt[16] = '{16'hCA05, 5'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h123C};
    vt[17] = '{16'hB105, 5'h00, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h123D};

    mem_rdata = 16'h0000;
    flags     = 5'h00;
    rsrc_data = 16'h0000;
    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 18; i++) begin
      ev.rf  = vt[i].rf;
      ev.fl  = vt[i].fl;
      ev.ld  = vt[i].ld;
      ev.st  = vt[i].st;
      ev.npc = vt[i].npc;
      run(vt[i].ins, vt[i].f, vt[i].rs, vt[i].fw, vt[i].mw,
          ev, $sformatf("vec%0d", i));
    end

    // reset in the middle of a stalled MEM access;
    // mem_ready high in DECODE/EXEC must not matter
    do_reset();
    mem_rdata = 16'h4203;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("midmem.state", state, 3);
    chk("midmem.pc", pc, 16'h0001);
    chk("midmem.addr_sel", mem_addr_sel, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midmem_rst");
    reset = 1'b0;
    exp_pc = 16'h0000;
    exp_ir = 16'h0000;

    // reset during a fetch stall
    ev = model(16'h5105, 5'h00, 16'h0000, exp_pc);
    run(16'h5105, 5'h00, 16'h0000, 0, 0, ev, "pre_stall");
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall.state", state, 0);
    chk("stall.pc", pc, 16'h0001);
    chk("stall.ir", ir, 16'h5105);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("stall_rst");
    reset = 1'b0;
    exp_pc = 16'h0000;
    exp_ir = 16'h0000;

    for (int i = 0; i < 300; i++) begin
      logic [15:0] ins, rs;
      logic [4:0]  f;
      int fw, mw;
      ins = rnd_ins();
      f   = 5'($urandom);
      rs  = 16'($urandom);
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      ev  = model(ins, f, rs, exp_pc);
      run(ins, f, rs, fw, mw, ev, $sformatf("rnd%0d_%h", i, ins));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
